// File: rtl/jk_seq_pkg.sv
// Shared types for the JK bank sequencing controller: FSM state encoding
// and the excitation pair that leaves a JK cell unchanged.
package jk_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LOAD = 2'd2
  } state_t;

  typedef struct packed {
    logic j;
    logic k;
  } jk_exc_t;

  localparam jk_exc_t JK_HOLD = '{j: 1'b0, k: 1'b0};

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop: 00 hold, 01 reset, 10 set, 11 toggle.
// Asynchronous active-high reset forces Q=0 / nQ=1.
module jk_cell (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q,
  output logic nq
);

  // JK storage element
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

  assign nq = ~q;

endmodule

// File: rtl/jk_seq_ctrl.sv
// Drives a bank of WIDTH JK cells as a loadable modulo-MOD counter with
// run/hold control. Define JK_SEQ_DOWN_EN to honour dir (down counting);
// without it the counter is up-only and dir is ignored.
//
// state   | meaning
// IDLE    | holding, waiting for en or a load
// RUN     | counting one step per cycle while en=1
// LOAD    | one-cycle hold after an accepted load; loads refused
module jk_seq_ctrl
  import jk_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_value,
  output logic             load_ready,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             wrap,
  output logic             busy
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MOD - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_wrap;
  logic             w_wrap_nxt;
  logic             w_accept;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_nxt;
  logic [WIDTH-1:0] w_nq_unused;

`ifndef JK_SEQ_DOWN_EN
  logic w_unused_dir;
  assign w_unused_dir = dir;
`endif

  assign load_ready = (r_state != ST_LOAD);
  assign w_accept   = load_valid & load_ready;

  // Target value for the bank after this edge, plus the wrap it implies
  always_comb begin
    w_nxt      = w_q;
    w_wrap_nxt = 1'b0;
    if (w_accept) begin
      w_nxt = (load_value > MAX_Q) ? MAX_Q : load_value;
    end else if (r_state == ST_RUN && en) begin
`ifdef JK_SEQ_DOWN_EN
      if (dir) begin
        if (w_q == '0) begin
          w_nxt      = MAX_Q;
          w_wrap_nxt = 1'b1;
        end else begin
          w_nxt = w_q - WIDTH'(1);
        end
      end else
`endif
      begin
        if (w_q == MAX_Q) begin
          w_nxt      = '0;
          w_wrap_nxt = 1'b1;
        end else begin
          w_nxt = w_q + WIDTH'(1);
        end
      end
    end
  end

  // FSM next state; a load always wins, otherwise en selects RUN or IDLE
  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) begin
      w_state_nxt = ST_LOAD;
    end else if (en) begin
      w_state_nxt = ST_RUN;
    end else begin
      w_state_nxt = ST_IDLE;
    end
  end

  // FSM state and wrap pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  // Set only bits rising, reset only bits falling; hold while in reset
  // so a load request during reset cannot leak through the excitation.
  assign j = rst ? {WIDTH{JK_HOLD.j}} : (~w_q & w_nxt);
  assign k = rst ? {WIDTH{JK_HOLD.k}} : (w_q & ~w_nxt);

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    jk_cell u_cell (
      .clk (clk),
      .rst (rst),
      .j   (j[g]),
      .k   (k[g]),
      .q   (w_q[g]),
      .nq  (w_nq_unused[g])
    );
  end

  assign q    = w_q;
  assign wrap = r_wrap;
  assign busy = (r_state == ST_RUN);

endmodule

// File: doc/jk_seq_ctrl.md
# jk_seq_ctrl

Sequencing controller for a bank of JK flip-flops. It owns WIDTH JK cells and computes their J/K excitation every cycle, so the bank behaves as a loadable modulo-MOD counter with run/hold control and an optional down-count direction. It sits between lab-level stimulus (switches, testbench) and the JK storage, and is the standard way the team drives JK banks as counters.

## Interface
- WIDTH, 4: number of JK cells / counter bits.
- MOD, 10: counter modulus; legal range 2 ≤ MOD ≤ 2^WIDTH.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  count enable; 1 = advance one step per cycle.
- dir  in  1  0 = up, 1 = down (only with JK_SEQ_DOWN_EN).
- load_valid  in  1  load request.
- load_value  in  WIDTH  value to load.
- load_ready  out  1  controller can accept a load this cycle.
- q  out  WIDTH  current JK bank state (Q outputs).
- j  out  WIDTH  current J excitation (combinational).
- k  out  WIDTH  current K excitation (combinational).
- wrap  out  1  one-cycle pulse on modulus wrap.
- busy  out  1  high in RUN state.

## Operation
- FSM states: IDLE, RUN, LOAD.
- IDLE: en=0 → stay; en=1 → RUN. RUN: en=0 → IDLE.
- Load accepted when load_valid & load_ready, in IDLE or RUN → LOAD. Load beats count (en ignored that cycle).
- LOAD: exactly one cycle; load_ready=0; excitation forced to hold; exit → RUN if en=1, else IDLE. load_valid in LOAD is ignored (not accepted).
- load_ready = 1 in IDLE and RUN, 0 in LOAD.
- Target next value nxt per cycle: accepted load → min(load_value, MOD-1); RUN & en & up → (q==MOD-1) ? 0 : q+1; RUN & en & down → (q==0) ? MOD-1 : q-1; else q (hold).
- Excitation per bit: j = ~q & nxt, k = q & ~nxt. Hold therefore gives j=k=0; never j=k=1 (toggle mode unused).
- q never leaves 0..MOD-1; arithmetic is WIDTH-bit, compare against MOD-1 only.
- wrap registered: set on the edge where q goes MOD-1→0 (up) or 0→MOD-1 (down); cleared next edge. Loads never assert wrap.
- Reset (any time, incl. mid-LOAD): q=0, state IDLE, wrap=0; so load_ready=1, busy=0, j=k=0 while rst held.

## Timing
- Count latency: q changes on the rising edge of the cycle where state=RUN and en=1.
- en rising in IDLE: first increment occurs one cycle later (IDLE→RUN edge does not count).
- Load latency: q = clamped load_value on the edge ending the accept cycle; next cycle LOAD (hold); counting resumes earliest the following edge.
- Back-to-back loads: minimum spacing two cycles.
- j/k valid combinationally within the cycle; cells sample them at the rising edge.
- rst release: first state change at the first rising edge after deassertion.

## Configuration
- JK_SEQ_DOWN_EN defined: dir honored as above.
- Not defined: dir ignored, counter is up-only, down wrap logic absent; port dir still present.

## Structure
- Package jk_seq_pkg: state enum (IDLE, RUN, LOAD), helper constant for hold excitation (j=0,k=0).
- Sub-module jk_cell: single JK flip-flop, rising-edge clk, async active-high rst to Q=0/nQ=1, modes hold/reset/set/toggle; instantiated WIDTH times via generate.
- Next-state/excitation logic combinational in jk_seq_ctrl; FSM and wrap register local.

## Test plan
- Reset then en=1, MOD=10: q steps 0,1,…,9,0; wrap high exactly in cycle q becomes 0; j/k never both 1.
- Load 7 in RUN (load_valid one cycle): q=7 next edge, load_ready=0 one cycle, q holds 7 one cycle, then 8,9,0 with wrap.
- Load 13 with MOD=10: q=9 (clamped), no wrap pulse; load_valid held during LOAD not re-accepted.
- JK_SEQ_DOWN_EN, dir=1 from q=1: q=0, then 9 with wrap; without macro same stimulus counts up 2,3.
- en toggled 1→0→1 at q=4: q holds 4 in IDLE, j=k=0, busy=0; resumes 5 one cycle after en returns.
- rst asserted mid-LOAD after loading 6: q=0 immediately (asynchronous), state IDLE, wrap=0, load_ready=1.
